pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised pipeline hazard/flush controller; successor to the decoder's pcsrc1/pcsrc2 flush logic.
//  Sits beside the opcode decoder in ID. Resolves control hazards (ID jump, EX branch), load-use
//  data hazards and multi-cycle EX ops. Drives PC/IF_ID write enables, flushes and EX hold.
//  Keeps saturating stall/flush counters for performance debug.
// PARAMETERS
//  REG_AW   4  register address width
//  NUM_SRC  2  source operands checked per ID instruction
//  MC_LAT   4  EX cycles taken by a multi-cycle op (>=1; 1 = no stall)
//  CNT_W   16  width of performance counters
// PORTS
//  clk          in   1               rising-edge clock
//  rst_n        in   1               async active-low reset
//  id_valid     in   1               ID stage holds a real instruction
//  id_src       in   REG_AW*NUM_SRC  ID source regs, src k at [k*REG_AW +: REG_AW]
//  id_src_used  in   NUM_SRC         per-source "actually read" flag
//  id_mc_op     in   1               ID instruction is multi-cycle
//  ex_memRead   in   1               EX instruction is a load
//  ex_rd        in   REG_AW          EX destination register
//  pcsrc1       in   1               jump taken, resolved in ID
//  pcsrc2       in   1               branch taken, resolved in EX
//  pc_write     out  1               PC update enable
//  if_id_write  out  1               IF/ID register enable
//  IF_ID_Flush  out  1               zero IF/ID next edge
//  ID_EX_Flush  out  1               insert bubble into ID/EX next edge
//  ex_hold      out  1               hold ID/EX + EX unit; bubble into EX/MEM
//  mc_busy      out  1               multi-cycle op in progress
//  stall_cnt    out  CNT_W           cycles with pc_write=0 (saturating)
//  flush_cnt    out  CNT_W           cycles with IF_ID_Flush=1 (saturating)
// BEHAVIOUR
//  - State FSM {RUN, MC_BUSY} + down-counter mc_cnt ($clog2(MC_LAT+1) bits); registered.
//  - Control outputs are combinational from state + inputs (same-cycle effect); counters registered.
//  - rst_n low (async): state=RUN, mc_cnt=0, counters=0; pc_write=0, if_id_write=0, all flushes=0,
//    ex_hold=0, mc_busy=0. First edge after release behaves as RUN.
//  - Default (RUN, no event): pc_write=1, if_id_write=1, flushes=0, ex_hold=0.
//  - Priority in RUN, highest first:
//    1 pcsrc2: IF_ID_Flush=1, ID_EX_Flush=1, pc_write=1, if_id_write=1; kills ID instr (no load-use
//      stall, no MC start even if id_mc_op).
//    2 pcsrc1: IF_ID_Flush=1, ID_EX_Flush=0, pc_write=1, if_id_write=1; ID instr proceeds, incl. MC start.
//    3 load-use: id_valid & ex_memRead & ex_rd!=0 & any k: id_src_used[k] & id_src[k]==ex_rd
//      -> pc_write=0, if_id_write=0, ID_EX_Flush=1 for exactly that cycle; no state change.
//    4 MC start: id_valid & id_mc_op & MC_LAT>1 & no load-use -> next state MC_BUSY, mc_cnt=MC_LAT-1.
//  - MC_BUSY: pc_write=0, if_id_write=0, ex_hold=1, mc_busy=1, flushes=0; mc_cnt decrements each edge;
//    transition to RUN on the edge where mc_cnt==1. Total EX occupancy = MC_LAT cycles.
//  - MC_BUSY: pcsrc2 cannot legally assert (EX is the MC op); ignored if it does. pcsrc1 in
//    MC_BUSY is ignored (ID frozen; re-presented after release).
//  - rst_n assertion mid-MC_BUSY aborts immediately to RUN, mc_cnt=0.
//  - stall_cnt += 1 each edge where pc_write=0 and rst_n high; flush_cnt likewise on IF_ID_Flush=1;
//    both saturate at 2^CNT_W-1, never wrap.
//  - Load-use with ex_rd==0 never stalls; unused sources (id_src_used[k]=0) never match.
// TESTING
//  - Reset: rst_n=0 mid-stream -> all controls 0, counters 0; release -> pc_write=1 next cycle.
//  - Load-use: ex_memRead=1, ex_rd=5, id_src[0]=5 used -> 1 cycle pc_write=0, ID_EX_Flush=1, stall_cnt=1.
//  - ex_rd=0 or matching src with id_src_used=0 -> no stall, pc_write stays 1.
//  - MC op, MC_LAT=4: id_mc_op=1 -> mc_busy/ex_hold high 3 cycles, then RUN; stall_cnt=3.
//  - pcsrc2 with load-use and id_mc_op both true -> both flushes=1, pc_write=1, no MC_BUSY entry.
//  - CNT_W=2: 5 consecutive stall cycles -> stall_cnt stops at 3; pcsrc1 -> flush_cnt+1 only.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard information in, pipeline enables, flushes and perf counters out.
// The pipeline side drives through master; the hazard controller attaches as slave.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic                      id_valid;
  logic [REG_AW*NUM_SRC-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic                      id_mc_op;
  logic                      ex_memRead;
  logic [REG_AW-1:0]         ex_rd;
  logic                      pcsrc1;
  logic                      pcsrc2;
  logic                      pc_write;
  logic                      if_id_write;
  logic                      IF_ID_Flush;
  logic                      ID_EX_Flush;
  logic                      ex_hold;
  logic                      mc_busy;
  logic [CNT_W-1:0]          stall_cnt;
  logic [CNT_W-1:0]          flush_cnt;

  modport master (
    output id_valid, id_src, id_src_used, id_mc_op, ex_memRead, ex_rd, pcsrc1, pcsrc2,
    input  pc_write, if_id_write, IF_ID_Flush, ID_EX_Flush, ex_hold, mc_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_mc_op, ex_memRead, ex_rd, pcsrc1, pcsrc2,
    output pc_write, if_id_write, IF_ID_Flush, ID_EX_Flush, ex_hold, mc_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/flush controller: control hazards, load-use stalls and multi-cycle EX holds,
// with saturating stall/flush counters for performance debug.
module pipe_hazard_ctrl #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int MC_LAT  = 4,
  parameter int CNT_W   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int               MC_W    = $clog2(MC_LAT + 1);
  localparam logic [MC_W-1:0]  MC_INIT = MC_W'(MC_LAT - 1);
  localparam logic [MC_W-1:0]  MC_ONE  = MC_W'(1);
  localparam logic [MC_W-1:0]  MC_ZERO = {MC_W{1'b0}};
  localparam logic             MC_EN   = (MC_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MC_BUSY = 1'b1;

  logic [0:0]       r_state;
  logic [MC_W-1:0]  r_mc_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [0:0]       w_nxt_state;
  logic [MC_W-1:0]  w_nxt_mc_cnt;
  logic             w_src_hit;
  logic             w_load_use;
  logic             w_mc_start;
  logic             w_pc_write;
  logic             w_if_id_write;
  logic             w_if_id_flush;
  logic             w_id_ex_flush;
  logic             w_ex_hold;
  logic             w_mc_busy;

  // Load-use detection: only sources the ID instruction really reads can collide with a load.
  always_comb begin
    w_src_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_src_hit = w_src_hit |
                  (hz.id_src_used[k] & (hz.id_src[k*REG_AW +: REG_AW] == hz.ex_rd));
    end
    w_load_use = hz.id_valid & hz.ex_memRead & (hz.ex_rd != {REG_AW{1'b0}}) & w_src_hit;
  end

  // A taken EX branch kills the ID instruction, so it may not launch a multi-cycle op.
  assign w_mc_start = MC_EN & hz.id_valid & hz.id_mc_op & ~w_load_use & ~hz.pcsrc2;

  // Same-cycle pipeline controls, forced inactive while reset is held.
  always_comb begin
    w_pc_write    = 1'b0;
    w_if_id_write = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_ex_hold     = 1'b0;
    w_mc_busy     = 1'b0;
    if (!rst_n) begin
      w_pc_write = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (hz.pcsrc2) begin
            w_pc_write    = 1'b1;
            w_if_id_write = 1'b1;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if (hz.pcsrc1) begin
            w_pc_write    = 1'b1;
            w_if_id_write = 1'b1;
            w_if_id_flush = 1'b1;
          end else if (w_load_use) begin
            w_id_ex_flush = 1'b1;
          end else begin
            w_pc_write    = 1'b1;
            w_if_id_write = 1'b1;
          end
        end
        ST_MC_BUSY: begin
          // Branch/jump requests are ignored here: EX and ID are both frozen.
          w_ex_hold = 1'b1;
          w_mc_busy = 1'b1;
        end
        default: begin
          w_pc_write = 1'b0;
        end
      endcase
    end
  end

  // Next-state logic for the RUN / MC_BUSY sequencer and its occupancy down-counter.
  always_comb begin
    w_nxt_state  = ST_RUN;
    w_nxt_mc_cnt = MC_ZERO;
    case (r_state)
      ST_RUN: begin
        if (w_mc_start) begin
          w_nxt_state  = ST_MC_BUSY;
          w_nxt_mc_cnt = MC_INIT;
        end else begin
          w_nxt_state  = ST_RUN;
          w_nxt_mc_cnt = MC_ZERO;
        end
      end
      ST_MC_BUSY: begin
        if (r_mc_cnt == MC_ONE) begin
          w_nxt_state  = ST_RUN;
          w_nxt_mc_cnt = MC_ZERO;
        end else begin
          w_nxt_state  = ST_MC_BUSY;
          w_nxt_mc_cnt = r_mc_cnt - MC_ONE;
        end
      end
      default: begin
        w_nxt_state  = ST_RUN;
        w_nxt_mc_cnt = MC_ZERO;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_mc_cnt <= MC_ZERO;
    end else begin
      r_state  <= w_nxt_state;
      r_mc_cnt <= w_nxt_mc_cnt;
    end
  end

  // Saturating performance counters; they hold at all-ones rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (!w_pc_write && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (w_if_id_flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign hz.pc_write    = w_pc_write;
  assign hz.if_id_write = w_if_id_write;
  assign hz.IF_ID_Flush = w_if_id_flush;
  assign hz.ID_EX_Flush = w_id_ex_flush;
  assign hz.ex_hold     = w_ex_hold;
  assign hz.mc_busy     = w_mc_busy;
  assign hz.stall_cnt   = r_stall_cnt;
  assign hz.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (16-bit and 2-bit counters) share directed stimulus;
// a rule-level model is compared every cycle, plus hand-computed literal expectations.
module tb_pipe_hazard_ctrl;

  localparam int MC_LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_mc_op, ex_memRead, pcsrc1, pcsrc2;
  logic [7:0] id_src;
  logic [1:0] id_src_used;
  logic [3:0] ex_rd;

  int n_cmp = 0;
  int n_bad = 0;

  int m_busy = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(4), .NUM_SRC(2), .CNT_W(16)) hz_a ();
  pipe_hazard_ctrl_if #(.REG_AW(4), .NUM_SRC(2), .CNT_W(2))  hz_b ();

  assign hz_a.id_valid = id_valid;       assign hz_b.id_valid = id_valid;
  assign hz_a.id_src = id_src;           assign hz_b.id_src = id_src;
  assign hz_a.id_src_used = id_src_used; assign hz_b.id_src_used = id_src_used;
  assign hz_a.id_mc_op = id_mc_op;       assign hz_b.id_mc_op = id_mc_op;
  assign hz_a.ex_memRead = ex_memRead;   assign hz_b.ex_memRead = ex_memRead;
  assign hz_a.ex_rd = ex_rd;             assign hz_b.ex_rd = ex_rd;
  assign hz_a.pcsrc1 = pcsrc1;           assign hz_b.pcsrc1 = pcsrc1;
  assign hz_a.pcsrc2 = pcsrc2;           assign hz_b.pcsrc2 = pcsrc2;

  pipe_hazard_ctrl #(.REG_AW(4), .NUM_SRC(2), .MC_LAT(MC_LAT), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .hz(hz_a));
  pipe_hazard_ctrl #(.REG_AW(4), .NUM_SRC(2), .MC_LAT(MC_LAT), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .hz(hz_b));

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_load_use();
    bit hit = 1'b0;
    for (int k = 0; k < 2; k++)
      if (id_src_used[k] && id_src[k*4 +: 4] == ex_rd) hit = 1'b1;
    return hit && id_valid && ex_memRead && ex_rd != 4'd0;
  endfunction

  // {pc_write, if_id_write, IF_ID_Flush, ID_EX_Flush, ex_hold, mc_busy}
  function automatic logic [5:0] model_ctl(input int busy);
    if (!rst_n)            return 6'b000000;
    if (busy > 0)          return 6'b000011;
    if (pcsrc2)            return 6'b111100;
    if (pcsrc1)            return 6'b111000;
    if (model_load_use())  return 6'b000100;
    return 6'b110000;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Model advance: remaining-busy count plus unbounded event totals.
  always @(posedge clk) begin
    logic [5:0] e;
    e = model_ctl(m_busy);
    if (!rst_n) begin
      m_busy  <= 0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      if (!e[5]) m_stall <= m_stall + 1;
      if (e[3])  m_flush <= m_flush + 1;
      if (m_busy > 0)
        m_busy <= m_busy - 1;
      else if (MC_LAT > 1 && id_valid && id_mc_op && !pcsrc2 && !model_load_use())
        m_busy <= MC_LAT - 1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [5:0] e;
    int es, ef;
    e  = model_ctl(m_busy);
    es = rst_n ? m_stall : 0;
    ef = rst_n ? m_flush : 0;
    chk("a.pc_write",    hz_a.pc_write,    e[5]);
    chk("a.if_id_write", hz_a.if_id_write, e[4]);
    chk("a.IF_ID_Flush", hz_a.IF_ID_Flush, e[3]);
    chk("a.ID_EX_Flush", hz_a.ID_EX_Flush, e[2]);
    chk("a.ex_hold",     hz_a.ex_hold,     e[1]);
    chk("a.mc_busy",     hz_a.mc_busy,     e[0]);
    chk("a.stall_cnt",   hz_a.stall_cnt,   sat(es, 65535));
    chk("a.flush_cnt",   hz_a.flush_cnt,   sat(ef, 65535));
    chk("b.pc_write",    hz_b.pc_write,    e[5]);
    chk("b.IF_ID_Flush", hz_b.IF_ID_Flush, e[3]);
    chk("b.ID_EX_Flush", hz_b.ID_EX_Flush, e[2]);
    chk("b.mc_busy",     hz_b.mc_busy,     e[0]);
    chk("b.stall_cnt",   hz_b.stall_cnt,   sat(es, 3));
    chk("b.flush_cnt",   hz_b.flush_cnt,   sat(ef, 3));
  end

  task automatic nop();
    id_valid = 1'b0; id_src = 8'h00; id_src_used = 2'b00; id_mc_op = 1'b0;
    ex_memRead = 1'b0; ex_rd = 4'd0; pcsrc1 = 1'b0; pcsrc2 = 1'b0;
  endtask

  task automatic load_use5();
    id_valid = 1'b1; ex_memRead = 1'b1; ex_rd = 4'd5; id_src = 8'h05; id_src_used = 2'b01;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  initial begin
    nop();
    rst_n = 1'b0;
    cyc(); cyc(); mid();
    chk("lit_rst_pc_write", hz_a.pc_write, 0);
    chk("lit_rst_if_id_write", hz_a.if_id_write, 0);
    chk("lit_rst_stall", hz_a.stall_cnt, 0);
    cyc(); rst_n = 1'b1; mid();
    chk("lit_release_pc_write", hz_a.pc_write, 1);

    cyc(); load_use5(); mid();
    chk("lit_lu_pc_write", hz_a.pc_write, 0);
    chk("lit_lu_id_ex_flush", hz_a.ID_EX_Flush, 1);
    cyc(); nop(); mid();
    chk("lit_lu_stall_cnt", hz_a.stall_cnt, 1);

    cyc(); load_use5(); ex_rd = 4'd0; id_src = 8'h00; id_src_used = 2'b11; mid();
    chk("lit_rd0_pc_write", hz_a.pc_write, 1);
    cyc(); load_use5(); ex_rd = 4'd7; id_src = 8'h07; id_src_used = 2'b10; mid();
    chk("lit_unused_pc_write", hz_a.pc_write, 1);
    cyc(); load_use5(); ex_rd = 4'd7; id_src = 8'h70; id_src_used = 2'b10; mid();
    chk("lit_src1_pc_write", hz_a.pc_write, 0);

    cyc(); nop(); rst_n = 1'b0; mid();
    chk("lit_midrst_stall", hz_a.stall_cnt, 0);
    cyc(); rst_n = 1'b1; mid();

    cyc(); id_valid = 1'b1; id_mc_op = 1'b1; mid();
    chk("lit_mc_issue_busy", hz_a.mc_busy, 0);
    chk("lit_mc_issue_pc_write", hz_a.pc_write, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); nop(); mid();
      chk("lit_mc_busy", hz_a.mc_busy, 1);
      chk("lit_mc_ex_hold", hz_a.ex_hold, 1);
    end
    cyc(); mid();
    chk("lit_mc_done_busy", hz_a.mc_busy, 0);
    chk("lit_mc_stall_a", hz_a.stall_cnt, 3);
    chk("lit_mc_stall_b", hz_b.stall_cnt, 3);

    cyc(); load_use5(); id_mc_op = 1'b1; pcsrc2 = 1'b1; mid();
    chk("lit_p2_if_flush", hz_a.IF_ID_Flush, 1);
    chk("lit_p2_ex_flush", hz_a.ID_EX_Flush, 1);
    chk("lit_p2_pc_write", hz_a.pc_write, 1);
    cyc(); nop(); mid();
    chk("lit_p2_no_mc", hz_a.mc_busy, 0);
    chk("lit_p2_flush_cnt", hz_a.flush_cnt, 1);

    cyc(); pcsrc1 = 1'b1; mid();
    chk("lit_p1_if_flush", hz_a.IF_ID_Flush, 1);
    chk("lit_p1_ex_flush", hz_a.ID_EX_Flush, 0);
    cyc(); nop(); mid();
    chk("lit_p1_flush_cnt", hz_a.flush_cnt, 2);
    chk("lit_p1_stall_cnt", hz_a.stall_cnt, 3);

    for (int i = 0; i < 5; i++) begin
      cyc(); load_use5();
    end
    cyc(); nop(); mid();
    chk("lit_sat_stall_b", hz_b.stall_cnt, 3);
    chk("lit_sat_stall_a", hz_a.stall_cnt, 8);

    cyc(); pcsrc1 = 1'b1; id_valid = 1'b1; id_mc_op = 1'b1; mid();
    chk("lit_p1mc_if_flush", hz_a.IF_ID_Flush, 1);
    cyc(); nop(); mid();
    chk("lit_p1mc_busy", hz_a.mc_busy, 1);
    cyc(); pcsrc1 = 1'b1; pcsrc2 = 1'b1; mid();
    chk("lit_busy_ign_if_flush", hz_a.IF_ID_Flush, 0);
    chk("lit_busy_ign_ex_flush", hz_a.ID_EX_Flush, 0);
    chk("lit_busy_ign_pc_write", hz_a.pc_write, 0);
    cyc(); nop(); mid();
    chk("lit_p1mc_busy3", hz_a.mc_busy, 1);
    cyc(); mid();
    chk("lit_p1mc_done", hz_a.mc_busy, 0);
    chk("lit_p1mc_flush_a", hz_a.flush_cnt, 3);
    chk("lit_p1mc_stall_a", hz_a.stall_cnt, 11);

    cyc(); pcsrc1 = 1'b1; cyc(); nop(); mid();
    chk("lit_sat_flush_a", hz_a.flush_cnt, 4);
    chk("lit_sat_flush_b", hz_b.flush_cnt, 3);

    cyc(); id_valid = 1'b1; id_mc_op = 1'b1;
    cyc(); nop(); mid();
    chk("lit_abort_pre_busy", hz_a.mc_busy, 1);
    cyc(); rst_n = 1'b0; mid();
    chk("lit_abort_busy", hz_a.mc_busy, 0);
    chk("lit_abort_hold", hz_a.ex_hold, 0);
    chk("lit_abort_stall", hz_a.stall_cnt, 0);
    cyc(); rst_n = 1'b1; mid();
    chk("lit_abort_rel_busy", hz_a.mc_busy, 0);
    chk("lit_abort_rel_pc_write", hz_a.pc_write, 1);
    cyc(); mid();
    chk("lit_abort_no_resume", hz_a.mc_busy, 0);

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
